tile_fetch_scheduler: RTL and testbench
=======================================

// Module: tile_fetch_scheduler
// PURPOSE
//  Schedules the single read port of the level tile RAM (20x15 grid of 32x32 px tiles, 3-bit type).
//  Two users share the port: display prefetch (fixed, priority) and game-logic collision queries (req/ack).
//  Prefetches the next tile column so blockType is already registered when the raster enters that tile.
//  Sits between the VGA timing counters and display_controller.
// PARAMETERS
//  TILE_LOG2  5       log2 tile edge in pixels (32)
//  COLS       20      tile columns in visible area
//  ROWS       15      tile rows in visible area
//  H_TOTAL    800     hCount period, incl. blanking
//  V_TOTAL    525     vCount period, incl. blanking
//  ADDR_W     9       tile RAM address width
//  OOB_TYPE   3'd1    type returned for an out-of-grid query (solid)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       synchronous reset, active low
//  pix_en     in   1       hCount/vCount advance after every clk with pix_en=1
//  hCount     in   10      raster column, 0..H_TOTAL-1
//  vCount     in   10      raster line, 0..V_TOTAL-1
//  ram_en     out  1       tile RAM read strobe (combinational)
//  ram_addr   out  ADDR_W  tile RAM address = row*COLS+col (combinational)
//  ram_data   in   3       tile RAM read data, valid 1 clk after ram_en
//  blockType  out  3       registered tile type under current pixel, to display_controller
//  q_req      in   1       collision query request, held until q_ack
//  q_row      in   4       query tile row, stable while q_req=1
//  q_col      in   5       query tile column, stable while q_req=1
//  q_ack      out  1       one-cycle pulse: q_data valid
//  q_data     out  3       query result, held until next q_ack
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): blockType=0, q_ack=0, q_data=0, pending=0, query FSM=IDLE.
//   ram_en forced 0 while rst_n=0. An in-flight query is dropped; a still-high q_req is re-served.
//  Display slot S: clk with pix_en=1 and hCount[4:0]==30.
//   Target pixel p=(hCount+2) mod H_TOTAL. col=p>>5.
//   line = vCount if p>=2 (i.e. hCount<H_TOTAL-2), else (vCount+1) mod V_TOTAL. row=line>>5.
//   If col<COLS and row<ROWS: ram_en=1, addr=row*COLS+col. Otherwise no RAM access; fetched type=0.
//  S+1: fetched type (ram_data or 0) written to pending.
//  blockType <= pending on clk with pix_en=1 and hCount[4:0]==31.
//   If that clk is S+1 (pix_en every clk), bypass: blockType <= fetched type directly.
//   Net effect: blockType changes exactly as hCount[4:0] wraps to 0.
//  Query FSM (IDLE, READ, DONE):
//   IDLE: q_req=1 and clk is not a display slot needing RAM -> grant.
//    Grant when in range (q_row<ROWS, q_col<COLS): ram_en=1, addr=q_row*COLS+q_col, go READ.
//    Grant when out of range: no RAM access, go READ with OOB flag set.
//   READ: q_data <= OOB ? OOB_TYPE : ram_data; q_ack <= 1; go DONE. A display slot may issue in READ.
//   DONE: q_ack=1 for this cycle only; no grant; go IDLE. Minimum 3 clk per query; next grant earliest clk after DONE.
//  Priority: display slot wins the port; a query colliding with S waits exactly 1 clk.
//   Slots are 1 in 32 pix_en cycles, so no starvation.
//  Display slot suppressed as out of range (blanking) does not block a query that cycle.
//  Port conflict impossible: ram_en asserted only in grant/slot cycles; each read's data is consumed by its owner at +1.
//  Address arithmetic: row*COLS+col fits ADDR_W (max 299); use COLS=20 as constant multiply, no wrap.
// TESTING
//  T1 RAM[0]=2, RAM[1]=5, pix_en=1 every clk, line 0 -> blockType=2 at hCount 0..31, 5 at hCount 32..63.
//  T2 pix_en=1 every 4th clk, same RAM -> identical blockType vs hCount as T1, via pending path.
//  T3 hCount=798, vCount=31, RAM[20]=4 -> ram_addr=20 at slot; blockType=4 when hCount=0, vCount=32.
//  T4 vCount=490 (row 15) or hCount=638 (col 20) -> no ram_en in slot; blockType=0 for those tiles.
//  T5 q_req row=3 col=7, RAM[67]=6, asserted on a slot clk -> grant 1 clk later; q_ack+q_data=6 two clk after grant.
//  T6 q_req col=25 -> no ram_en, q_ack with q_data=1. Reset pulsed in READ -> no q_ack; query re-served after reset.

Source files
------------

// File: rtl/tile_fetch_if.sv
// Raster, tile RAM and collision-query signals shared by the tile fetch scheduler and its surroundings.
interface tile_fetch_if #(
    parameter int ADDR_W = 9
);
    logic              pix_en;
    logic [9:0]        hCount;
    logic [9:0]        vCount;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [2:0]        ram_data;
    logic [2:0]        blockType;
    logic              q_req;
    logic [3:0]        q_row;
    logic [4:0]        q_col;
    logic              q_ack;
    logic [2:0]        q_data;

    modport master (
        output pix_en, hCount, vCount, ram_data, q_req, q_row, q_col,
        input  ram_en, ram_addr, blockType, q_ack, q_data
    );

    modport slave (
        input  pix_en, hCount, vCount, ram_data, q_req, q_row, q_col,
        output ram_en, ram_addr, blockType, q_ack, q_data
    );
endinterface

// File: rtl/tile_fetch_scheduler.sv
// Shares the single tile RAM read port between display prefetch (priority) and collision queries,
// prefetching two pixels ahead so blockType flips exactly as the raster enters each tile.
module tile_fetch_scheduler #(
    parameter int         TILE_LOG2 = 5,
    parameter int         COLS      = 20,
    parameter int         ROWS      = 15,
    parameter int         H_TOTAL   = 800,
    parameter int         V_TOTAL   = 525,
    parameter int         ADDR_W    = 9,
    parameter logic [2:0] OOB_TYPE  = 3'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    tile_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DONE} q_state_t;

    localparam logic [TILE_LOG2-1:0] SLOT_PX = TILE_LOG2'((1 << TILE_LOG2) - 2);
    localparam logic [TILE_LOG2-1:0] LAST_PX = '1;
    localparam logic [4:0]           COLS_C  = 5'(COLS);
    localparam logic [4:0]           ROWS_C  = 5'(ROWS);
    localparam logic [3:0]           ROWS_Q  = 4'(ROWS);

    logic [TILE_LOG2-1:0] tile_px;
    logic [10:0]          p_sum;
    logic [10:0]          p;
    logic [9:0]           line;
    logic [4:0]           slot_col;
    logic [4:0]           slot_row;
    logic                 slot;
    logic                 slot_hit;
    logic [ADDR_W-1:0]    slot_addr;
    logic [ADDR_W-1:0]    q_addr;
    logic                 q_in_range;
    logic                 grant;
    logic                 slot_d;
    logic                 slot_hit_d;
    logic [2:0]           fetched;
    logic [2:0]           pending;
    logic                 q_oob;
    q_state_t             state;
    q_state_t             state_nxt;

    assign tile_px = bus.hCount[TILE_LOG2-1:0];

    // Target pixel is two ahead; the last two pixels of a line look at the next line.
    always_comb begin
        p_sum = {1'b0, bus.hCount} + 11'd2;
        p     = (p_sum >= 11'(H_TOTAL)) ? p_sum - 11'(H_TOTAL) : p_sum;
        if (bus.hCount < 10'(H_TOTAL - 2))
            line = bus.vCount;
        else if (bus.vCount == 10'(V_TOTAL - 1))
            line = '0;
        else
            line = bus.vCount + 10'd1;
        slot_col = 5'(p >> TILE_LOG2);
        slot_row = 5'(line >> TILE_LOG2);
    end

    assign slot       = bus.pix_en && (tile_px == SLOT_PX);
    assign slot_hit   = slot && (slot_col < COLS_C) && (slot_row < ROWS_C);
    assign slot_addr  = ADDR_W'(slot_row) * ADDR_W'(COLS) + ADDR_W'(slot_col);
    assign q_addr     = ADDR_W'(bus.q_row) * ADDR_W'(COLS) + ADDR_W'(bus.q_col);
    assign q_in_range = (bus.q_row < ROWS_Q) && (bus.q_col < COLS_C);
    assign fetched    = slot_hit_d ? bus.ram_data : 3'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = READ;
            READ:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Port arbitration: an in-grid display slot always owns the port, a query just slips a clock.
    always_comb begin
        grant        = (state == IDLE) && bus.q_req && !slot_hit;
        bus.ram_en   = rst_n && (slot_hit || (grant && q_in_range));
        bus.ram_addr = slot_hit ? slot_addr : q_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_d        <= 1'b0;
            slot_hit_d    <= 1'b0;
            pending       <= 3'd0;
            bus.blockType <= 3'd0;
            q_oob         <= 1'b0;
            bus.q_ack     <= 1'b0;
            bus.q_data    <= 3'd0;
        end else begin
            slot_d     <= slot;
            slot_hit_d <= slot_hit;
            if (slot_d) pending <= fetched;
            // With pix_en every clk the fetch lands on the same clk that must publish it.
            if (bus.pix_en && (tile_px == LAST_PX))
                bus.blockType <= slot_d ? fetched : pending;
            if (grant) q_oob <= !q_in_range;
            bus.q_ack <= (state == READ);
            if (state == READ) bus.q_data <= q_oob ? OOB_TYPE : bus.ram_data;
        end
    end
endmodule

// File: tb/tb_tile_fetch_scheduler.sv
// Bench for tile_fetch_scheduler: slot decode table, directed corner sequences, randomized raster/query traffic.
module tb_tile_fetch_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tile_fetch_if #(.ADDR_W(9)) bus();
    tile_fetch_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        bit pe;
        int h;
        int v;
        bit en;
        int addr;
    } vec_t;

    logic [2:0] mem [0:299];
    int nvec = 0, nerr = 0, cyc = 0;
    bit rst_v, pe_v, qreq_v;
    int h, v, qr, qc;
    logic [2:0] last_fetch, exp_bt, exp_qdata, qval;
    bit exp_qack, granted;
    int grant_cyc, earliest;
    bit obs_en;
    int obs_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s (cyc %0d h=%0d v=%0d): got %0d, expected %0d", name, cyc, h, v, act, expv);
        end
    endtask

    function automatic int tgt_col(input int hh);
        return ((hh + 2) % 800) / 32;
    endfunction

    function automatic int tgt_row(input int hh, input int vv);
        return ((hh < 798) ? vv : (vv + 1) % 525) / 32;
    endfunction

    function automatic logic [2:0] tile(input int c, input int r);
        return (c < 20 && r < 15) ? mem[r * 20 + c] : 3'd0;
    endfunction

    // One clock: drive, check the port owner, update the reference, answer the RAM, check registered outputs.
    task automatic cycle();
        bit slot, shit, qg, inr;
        int sc, sr;
        rst_n = rst_v;
        bus.pix_en = pe_v;
        bus.hCount = 10'(h);
        bus.vCount = 10'(v);
        bus.q_req  = qreq_v;
        bus.q_row  = 4'(qr);
        bus.q_col  = 5'(qc);
        #1;
        slot = rst_v && pe_v && (h % 32 == 30);
        sc   = tgt_col(h);
        sr   = tgt_row(h, v);
        shit = slot && sc < 20 && sr < 15;
        inr  = qr < 15 && qc < 20;
        qg   = rst_v && qreq_v && !granted && cyc >= earliest && !shit;
        obs_en   = bus.ram_en;
        obs_addr = int'(bus.ram_addr);
        chk("ram_en", bus.ram_en, shit || (qg && inr));
        if (shit)            chk("slot_addr", bus.ram_addr, sr * 20 + sc);
        else if (qg && inr)  chk("query_addr", bus.ram_addr, qr * 20 + qc);
        if (qg) begin
            granted   = 1'b1;
            grant_cyc = cyc;
            qval      = inr ? mem[qr * 20 + qc] : 3'd1;
        end
        @(posedge clk);
        if (!rst_v) begin
            last_fetch = 3'd0; exp_bt = 3'd0; exp_qack = 1'b0; exp_qdata = 3'd0;
            granted = 1'b0; earliest = cyc + 1;
        end else begin
            if (slot) last_fetch = shit ? tile(sc, sr) : 3'd0;
            if (pe_v && h % 32 == 31) exp_bt = last_fetch;
            exp_qack = 1'b0;
            if (granted && cyc == grant_cyc + 1) begin
                exp_qack = 1'b1; exp_qdata = qval; granted = 1'b0; earliest = cyc + 2;
            end
        end
        @(negedge clk);
        bus.ram_data = (obs_en && obs_addr < 300) ? mem[obs_addr] : 3'($urandom_range(0, 7));
        if (pe_v) begin
            h++;
            if (h == 800) begin h = 0; v = (v + 1) % 525; end
        end
        chk("blockType", bus.blockType, exp_bt);
        chk("q_ack", bus.q_ack, exp_qack);
        chk("q_data", bus.q_data, exp_qdata);
        cyc++;
    endtask

    initial begin
        vec_t tbl [12];
        int h0, prob;
        int vpick [8];
        tbl[0]  = '{1, 30,  0,   1, 1};
        tbl[1]  = '{1, 798, 31,  1, 20};
        tbl[2]  = '{1, 30,  490, 0, 0};
        tbl[3]  = '{1, 638, 0,   0, 0};
        tbl[4]  = '{0, 30,  0,   0, 0};
        tbl[5]  = '{1, 31,  0,   0, 0};
        tbl[6]  = '{1, 798, 524, 1, 0};
        tbl[7]  = '{1, 606, 479, 1, 299};
        tbl[8]  = '{1, 766, 0,   0, 0};
        tbl[9]  = '{1, 62,  100, 1, 62};
        tbl[10] = '{1, 798, 479, 0, 0};
        tbl[11] = '{1, 798, 478, 1, 280};
        vpick = '{0, 31, 32, 479, 480, 490, 524, 250};

        for (int i = 0; i < 300; i++) mem[i] = 3'd0;
        rst_v = 1'b0; pe_v = 1'b0; qreq_v = 1'b0; h = 0; v = 0; qr = 0; qc = 0;
        last_fetch = 3'd0; exp_bt = 3'd0; exp_qdata = 3'd0; qval = 3'd0;
        exp_qack = 1'b0; granted = 1'b0; grant_cyc = 0; earliest = 0;
        obs_en = 1'b0; obs_addr = 0;
        rst_n = 1'b1; bus.ram_data = 3'd0; bus.q_req = 1'b0; bus.q_row = 4'd0; bus.q_col = 5'd0;
        bus.pix_en = 1'b0; bus.hCount = 10'd0; bus.vCount = 10'd0;

        // Display slot decode table.
        foreach (tbl[i]) begin
            @(negedge clk);
            bus.pix_en = tbl[i].pe;
            bus.hCount = 10'(tbl[i].h);
            bus.vCount = 10'(tbl[i].v);
            #1;
            chk("tbl_ram_en", bus.ram_en, tbl[i].en);
            if (tbl[i].en) chk("tbl_ram_addr", bus.ram_addr, tbl[i].addr);
        end
        @(negedge clk);

        // T1: pix_en every clk, line 0 entered from the end of the last line.
        mem[0] = 3'd2; mem[1] = 3'd5;
        rst_v = 1'b0; h = 768; v = 524;
        cycle(); cycle();
        rst_v = 1'b1; pe_v = 1'b1;
        for (int k = 0; k < 200 && !(v == 0 && h == 64); k++) begin
            cycle();
            if (v == 0 && h < 64) chk("T1_blockType", bus.blockType, (h < 32) ? 2 : 5);
        end
        chk("T1_reached", (v == 0 && h == 64), 1);

        // T2: pix_en every 4th clk, same picture through the pending register.
        rst_v = 1'b0; pe_v = 1'b0; h = 768; v = 524;
        cycle(); cycle();
        rst_v = 1'b1;
        for (int k = 0; k < 600 && !(v == 0 && h == 64); k++) begin
            pe_v = (k % 4 == 0);
            cycle();
            if (v == 0 && h < 64) chk("T2_blockType", bus.blockType, (h < 32) ? 2 : 5);
        end
        chk("T2_reached", (v == 0 && h == 64), 1);

        // T3: line wrap prefetch.
        mem[20] = 3'd4; pe_v = 1'b1; h = 792; v = 31;
        for (int k = 0; k < 8; k++) begin
            h0 = h;
            cycle();
            if (h0 == 798) begin
                chk("T3_ram_en", obs_en, 1);
                chk("T3_ram_addr", obs_addr, 20);
            end
        end
        chk("T3_blockType", bus.blockType, 4);

        // T4: column 20 and row 15 are never fetched and read as 0.
        mem[19] = 3'd3; h = 600; v = 0;
        while (h != 640) begin
            h0 = h;
            cycle();
            if (h0 == 638) chk("T4_col_ram_en", obs_en, 0);
            if (h >= 608 && h < 640) chk("T4_blockType19", bus.blockType, 3);
        end
        chk("T4_blockType20", bus.blockType, 0);
        h = 24; v = 0;
        while (h != 40) cycle();
        chk("T4_blockType1", bus.blockType, 5);
        v = 490;
        while (h != 64) begin
            h0 = h;
            cycle();
            if (h0 == 62) chk("T4_row_ram_en", obs_en, 0);
        end
        chk("T4_row15_blockType", bus.blockType, 0);

        // T5: query colliding with a display slot waits one clk.
        mem[67] = 3'd6; h = 26; v = 0;
        while (h != 30) cycle();
        qreq_v = 1'b1; qr = 3; qc = 7;
        cycle();
        chk("T5_slot_addr", obs_addr, 1);
        cycle();
        chk("T5_grant_en", obs_en, 1);
        chk("T5_grant_addr", obs_addr, 67);
        chk("T5_no_early_ack", bus.q_ack, 0);
        cycle();
        chk("T5_ack", bus.q_ack, 1);
        chk("T5_data", bus.q_data, 6);
        qreq_v = 1'b0;
        cycle();
        chk("T5_ack_pulse", bus.q_ack, 0);
        chk("T5_data_held", bus.q_data, 6);

        // T6: out-of-grid query, then reset while a query is in READ.
        pe_v = 1'b0; qreq_v = 1'b1; qr = 2; qc = 25;
        cycle();
        chk("T6_oob_ram_en", obs_en, 0);
        cycle();
        chk("T6_oob_ack", bus.q_ack, 1);
        chk("T6_oob_data", bus.q_data, 1);
        qreq_v = 1'b0; cycle();
        qreq_v = 1'b1; qr = 3; qc = 7;
        cycle();
        rst_v = 1'b0; cycle();
        chk("T6_rst_no_ack", bus.q_ack, 0);
        rst_v = 1'b1;
        cycle();
        chk("T6_reserve_en", obs_en, 1);
        chk("T6_reserve_addr", obs_addr, 67);
        cycle();
        chk("T6_reserve_ack", bus.q_ack, 1);
        chk("T6_reserve_data", bus.q_data, 6);
        qreq_v = 1'b0; cycle();

        // Randomized traffic against the reference.
        for (int i = 0; i < 300; i++) mem[i] = 3'($urandom_range(0, 7));
        rst_v = 1'b0; cycle(); rst_v = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            prob = (n < 1000) ? 100 : (n < 2000) ? 60 : (n < 3000) ? 25 : 100;
            pe_v = ($urandom_range(0, 99) < prob);
            if ($urandom_range(0, 149) == 0) begin
                h = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 799) : $urandom_range(760, 799);
                v = vpick[$urandom_range(0, 7)];
            end
            rst_v = ($urandom_range(0, 499) != 0);
            if (!qreq_v && $urandom_range(0, 2) == 0) begin
                qreq_v = 1'b1;
                qr = $urandom_range(0, 15);
                qc = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 19) : $urandom_range(20, 31);
            end
            cycle();
            if (exp_qack) qreq_v = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
